ps2_keycode_decoder: RTL and testbench

Decodes the byte stream from the PS/2 receiver front end (scan-code set 2) into single key events. Each event carries the base scan code, a break (release) flag and an extended (E0) flag. Events are buffered in a small FIFO behind a valid/ready handshake, and the block also keeps live Shift/Ctrl/Alt modifier state. It sits directly downstream of the PS/2 receiver and feeds the keyboard consumer logic.

---
 rtl/ps2_keycode_decoder_pkg.sv | 43 ++++
 rtl/ps2_event_fifo.sv | 61 ++++++
 rtl/ps2_keycode_decoder.sv | 179 +++++++++++++++++
 tb/tb_ps2_keycode_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keycode_decoder_pkg.sv
// Shared types and byte constants for the PS/2 set-2 keycode decoder.
// The decoder FSM states and the buffered key event format live here.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } state_t;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_E1 = 8'hE1;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam logic [7:0] CODE_AA = 8'hAA;
  localparam logic [7:0] CODE_FA = 8'hFA;
  localparam logic [7:0] CODE_FE = 8'hFE;
  localparam logic [7:0] CODE_00 = 8'h00;
  localparam logic [7:0] CODE_FC = 8'hFC;
  localparam logic [7:0] CODE_FF = 8'hFF;

  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_ALT    = 8'h11;

  // Pause/Break is E1 followed by seven more bytes that carry no key event.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Keyboard status/handshake bytes that may appear between scan codes.
  function automatic logic isIdleNoise(input logic [7:0] code);
    return (code == CODE_00) || (code == CODE_AA) || (code == CODE_FA) ||
           (code == CODE_FC) || (code == CODE_FE) || (code == CODE_FF);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Small synchronous FIFO of decoded key events with registered pointers
// and an occupancy count; the head entry is shown directly on o_head.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  ps2_event_t i_push_data,
  input  logic       i_pop,
  output ps2_event_t o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  ps2_event_t     r_mem [DEPTH];
  logic [AW-1:0]  r_wrPtr;
  logic [AW-1:0]  r_rdPtr;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_COUNT);
  assign w_pop   = i_pop && !o_empty;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = o_empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_mem[r_wrPtr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keycode_decoder.sv
// Turns the PS/2 set-2 byte stream into make/break key events, buffers them
// behind a valid/ready handshake and tracks live Shift/Ctrl/Alt state.
module ps2_keycode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_ps2_code,
  input  logic       i_ps2_code_new,
  input  logic       i_ps2_valid,
  output logic       o_ev_valid,
  input  logic       i_ev_ready,
  output logic [7:0] o_ev_code,
  output logic       o_ev_break,
  output logic       o_ev_ext,
  output logic       o_mod_shift,
  output logic       o_mod_ctrl,
  output logic       o_mod_alt,
  output logic       o_overflow
);

  state_t     r_state;
  logic [2:0] r_skipCnt;
  logic       r_lshift, r_rshift, r_lctrl, r_rctrl, r_lalt, r_ralt;
  logic       r_overflow;

  logic       w_accept;
  logic       w_abort;
  logic       w_emit;
  ps2_event_t w_event;
  ps2_event_t w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_drop;

  assign w_accept = i_ps2_code_new && i_ps2_valid;
  assign w_abort  = i_ps2_code_new && !i_ps2_valid;
  assign w_pop    = !w_empty && i_ev_ready;
  assign w_drop   = w_emit && w_full && !w_pop;

  // Decide whether the byte arriving now completes a key event.
  always_comb begin
    w_emit       = 1'b0;
    w_event.ext  = 1'b0;
    w_event.brk  = 1'b0;
    w_event.code = i_ps2_code;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (i_ps2_code != CODE_E0 && i_ps2_code != CODE_F0 &&
              i_ps2_code != CODE_E1 && !isIdleNoise(i_ps2_code)) begin
            w_emit = 1'b1;
          end
        end
        EXT: begin
          if (i_ps2_code != CODE_E0 && i_ps2_code != CODE_F0) begin
            w_emit      = 1'b1;
            w_event.ext = 1'b1;
          end
        end
        BRK: begin
          if (i_ps2_code != CODE_E0 && i_ps2_code != CODE_F0) begin
            w_emit      = 1'b1;
            w_event.brk = 1'b1;
          end
        end
        EXT_BRK: begin
          if (i_ps2_code != CODE_E0 && i_ps2_code != CODE_F0) begin
            w_emit      = 1'b1;
            w_event.ext = 1'b1;
            w_event.brk = 1'b1;
          end
        end
        default: w_emit = 1'b0;
      endcase
      // E0-prefixed shift codes are the keyboard's fake shifts around cursor keys.
      if (w_event.ext && (i_ps2_code == CODE_LSHIFT || i_ps2_code == CODE_RSHIFT)) begin
        w_emit = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_skipCnt <= '0;
    end else if (w_abort) begin
      r_state   <= IDLE;
      r_skipCnt <= '0;
    end else if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (i_ps2_code == CODE_E0) begin
            r_state <= EXT;
          end else if (i_ps2_code == CODE_F0) begin
            r_state <= BRK;
          end else if (i_ps2_code == CODE_E1) begin
            r_state   <= SKIP;
            r_skipCnt <= PAUSE_SKIP;
          end
        end
        EXT: begin
          if (i_ps2_code == CODE_F0) begin
            r_state <= EXT_BRK;
          end else if (i_ps2_code != CODE_E0) begin
            r_state <= IDLE;
          end
        end
        SKIP: begin
          if (r_skipCnt <= 3'd1) begin
            r_state   <= IDLE;
            r_skipCnt <= '0;
          end else begin
            r_skipCnt <= r_skipCnt - 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Modifiers follow every emitted event, whether or not the FIFO had room.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lshift   <= 1'b0;
      r_rshift   <= 1'b0;
      r_lctrl    <= 1'b0;
      r_rctrl    <= 1'b0;
      r_lalt     <= 1'b0;
      r_ralt     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_emit) begin
        case (w_event.code)
          CODE_LSHIFT: r_lshift <= !w_event.brk;
          CODE_RSHIFT: r_rshift <= !w_event.brk;
          CODE_CTRL: begin
            if (w_event.ext) r_rctrl <= !w_event.brk;
            else             r_lctrl <= !w_event.brk;
          end
          CODE_ALT: begin
            if (w_event.ext) r_ralt <= !w_event.brk;
            else             r_lalt <= !w_event.brk;
          end
          default: ;
        endcase
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_emit),
    .i_push_data (w_event),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign o_ev_valid  = !w_empty;
  assign o_ev_code   = w_head.code;
  assign o_ev_break  = w_head.brk;
  assign o_ev_ext    = w_head.ext;
  assign o_mod_shift = r_lshift || r_rshift;
  assign o_mod_ctrl  = r_lctrl || r_rctrl;
  assign o_mod_alt   = r_lalt || r_ralt;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// Directed self-checking bench for ps2_keycode_decoder; every expected value
// below is hand-derived from the scan-code set 2 decoding rules.
module tb_ps2_keycode_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ps2Code = 8'h00;
  logic       ps2CodeNew = 1'b0;
  logic       ps2Valid = 1'b0;
  logic       evReady = 1'b0;
  logic       evValid, evBreak, evExt;
  logic [7:0] evCode;
  logic       modShift, modCtrl, modAlt, overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_keycode_decoder #(.FIFO_DEPTH(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_ps2_code     (ps2Code),
    .i_ps2_code_new (ps2CodeNew),
    .i_ps2_valid    (ps2Valid),
    .o_ev_valid     (evValid),
    .i_ev_ready     (evReady),
    .o_ev_code      (evCode),
    .o_ev_break     (evBreak),
    .o_ev_ext       (evExt),
    .o_mod_shift    (modShift),
    .o_mod_ctrl     (modCtrl),
    .o_mod_alt      (modAlt),
    .o_overflow     (overflow)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic applyStimulus(input logic [7:0] code, input logic valid);
    ps2Code    = code;
    ps2CodeNew = 1'b1;
    ps2Valid   = valid;
    @(negedge clk);
    ps2CodeNew = 1'b0;
    ps2Valid   = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic popEvent();
    evReady = 1'b1;
    @(negedge clk);
    evReady = 1'b0;
  endtask

  task automatic expectEvent(input string tag, input logic ext, input logic brk,
                             input logic [7:0] code);
    checkOutput({tag, " valid"}, 16'(evValid), 16'd1);
    checkOutput({tag, " head"}, {6'b0, evExt, evBreak, evCode}, {6'b0, ext, brk, code});
    popEvent();
  endtask

  task automatic checkMods(input string tag, input logic s, input logic c, input logic a);
    checkOutput(tag, {13'b0, modShift, modCtrl, modAlt}, {13'b0, s, c, a});
  endtask

  task automatic checkAllReset(input string tag);
    checkOutput(tag, {1'b0, evValid, evCode, evBreak, evExt, modShift, modCtrl, modAlt, overflow},
                16'h0000);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    checkAllReset("reset state");
    rst = 1'b0;
    @(negedge clk);

    // Plain make and break
    applyStimulus(8'h1C, 1'b1);
    expectEvent("make 1C", 1'b0, 1'b0, 8'h1C);
    applyStimulus(8'hF0, 1'b1);
    checkOutput("F0 alone no event", 16'(evValid), 16'd0);
    applyStimulus(8'h1C, 1'b1);
    expectEvent("break 1C", 1'b0, 1'b1, 8'h1C);
    checkOutput("no overflow", 16'(overflow), 16'd0);

    // Extended make and break
    applyStimulus(8'hE0, 1'b1);
    applyStimulus(8'h75, 1'b1);
    expectEvent("make E0 75", 1'b1, 1'b0, 8'h75);
    applyStimulus(8'hE0, 1'b1);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h75, 1'b1);
    expectEvent("break E0 75", 1'b1, 1'b1, 8'h75);

    // Modifiers and fake shift
    applyStimulus(8'h12, 1'b1);
    checkMods("lshift make", 1'b1, 1'b0, 1'b0);
    expectEvent("make 12", 1'b0, 1'b0, 8'h12);
    applyStimulus(8'hE0, 1'b1);
    applyStimulus(8'h12, 1'b1);
    checkOutput("fake shift no event", 16'(evValid), 16'd0);
    checkMods("fake shift keeps mods", 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h12, 1'b1);
    checkMods("lshift break", 1'b0, 1'b0, 1'b0);
    expectEvent("break 12", 1'b0, 1'b1, 8'h12);
    applyStimulus(8'hE0, 1'b1);
    applyStimulus(8'h14, 1'b1);
    checkMods("rctrl make", 1'b0, 1'b1, 1'b0);
    expectEvent("make E0 14", 1'b1, 1'b0, 8'h14);
    applyStimulus(8'hE0, 1'b1);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h14, 1'b1);
    checkMods("rctrl break", 1'b0, 1'b0, 1'b0);
    expectEvent("break E0 14", 1'b1, 1'b1, 8'h14);
    applyStimulus(8'h59, 1'b1);
    expectEvent("make 59", 1'b0, 1'b0, 8'h59);
    applyStimulus(8'h11, 1'b1);
    checkMods("rshift and lalt", 1'b1, 1'b0, 1'b1);
    expectEvent("make 11", 1'b0, 1'b0, 8'h11);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h59, 1'b1);
    expectEvent("break 59", 1'b0, 1'b1, 8'h59);
    applyStimulus(8'hE0, 1'b1);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h11, 1'b1);
    checkMods("ralt break keeps lalt", 1'b0, 1'b0, 1'b1);
    expectEvent("break E0 11", 1'b1, 1'b1, 8'h11);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h11, 1'b1);
    checkMods("lalt break", 1'b0, 1'b0, 1'b0);
    expectEvent("break 11", 1'b0, 1'b1, 8'h11);

    // Pause sequence is swallowed, status bytes ignored
    applyStimulus(8'hE1, 1'b1);
    applyStimulus(8'h14, 1'b1);
    applyStimulus(8'h77, 1'b1);
    applyStimulus(8'hE1, 1'b1);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h14, 1'b1);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h77, 1'b1);
    checkOutput("pause no event", 16'(evValid), 16'd0);
    checkMods("pause no mods", 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1'b1);
    expectEvent("make after pause", 1'b0, 1'b0, 8'h1C);
    checkOutput("single event after pause", 16'(evValid), 16'd0);
    applyStimulus(8'hAA, 1'b1);
    applyStimulus(8'hFA, 1'b1);
    applyStimulus(8'hFE, 1'b1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("status bytes ignored", 16'(evValid), 16'd0);

    // Fill, overflow, modifier update while full, push+pop while full
    applyStimulus(8'h16, 1'b1);
    applyStimulus(8'h1E, 1'b1);
    applyStimulus(8'h26, 1'b1);
    applyStimulus(8'h25, 1'b1);
    checkOutput("full no overflow yet", 16'(overflow), 16'd0);
    applyStimulus(8'h2E, 1'b1);
    checkOutput("overflow set", 16'(overflow), 16'd1);
    checkOutput("head still first", {8'b0, evCode}, 16'h0016);
    applyStimulus(8'h12, 1'b1);
    checkMods("shift while full", 1'b1, 1'b0, 1'b0);
    evReady = 1'b1;
    applyStimulus(8'h36, 1'b1);
    evReady = 1'b0;
    expectEvent("drain 1E", 1'b0, 1'b0, 8'h1E);
    expectEvent("drain 26", 1'b0, 1'b0, 8'h26);
    expectEvent("drain 25", 1'b0, 1'b0, 8'h25);
    expectEvent("drain 36", 1'b0, 1'b0, 8'h36);
    checkOutput("drained empty", 16'(evValid), 16'd0);
    checkOutput("overflow sticky", 16'(overflow), 16'd1);
    applyStimulus(8'hF0, 1'b1);
    applyStimulus(8'h12, 1'b1);
    checkMods("shift released", 1'b0, 1'b0, 1'b0);
    expectEvent("break 12 after drain", 1'b0, 1'b1, 8'h12);

    // Invalid strobe aborts a pending E0
    applyStimulus(8'hE0, 1'b1);
    applyStimulus(8'h75, 1'b0);
    checkOutput("invalid byte no event", 16'(evValid), 16'd0);
    applyStimulus(8'h1C, 1'b1);
    expectEvent("make after abort", 1'b0, 1'b0, 8'h1C);

    // Reset mid-sequence with a queued event and held Ctrl
    applyStimulus(8'h14, 1'b1);
    applyStimulus(8'hF0, 1'b1);
    checkMods("lctrl before reset", 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    applyStimulus(8'h1C, 1'b1);
    checkAllReset("reset flush");
    rst = 1'b0;
    @(negedge clk);
    checkAllReset("after reset release");
    applyStimulus(8'h1C, 1'b1);
    expectEvent("make after reset", 1'b0, 1'b0, 8'h1C);
    checkOutput("empty at end", 16'(evValid), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
